operand_encoder: RTL
====================

// Module: operand_encoder
// PURPOSE
//  Inverse of the operand decode stage: takes one decoded-operand request (mode, reg ids, scale/disp/imm)
//  and serializes the x86-64 operand bytes (ModRM, SIB, disp, imm) one byte per cycle, plus REX.WRXB bits.
//  Feeds the test-program generator and round-trip checks against the decoder. No prefix/opcode bytes.
// PARAMETERS
//  DISP_W  32  width of in_disp (signed; only disp8/disp32 encodings produced)
//  IMM_W   64  width of in_imm (low 1/2/4/8 bytes emitted, little-endian)
// PORTS
//  clk        in   1      clock
//  reset      in   1      async active-high reset
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid&&in_ready
//  in_mode    in   5      enc_mode_t: RAX$R8..RDI$R15, *_IV, EV, EV_GV, EV_IB, EV_IZ, GV_EV, GV_M, RAX_IZ, JZ, JB, M, NONE
//  in_opsize  in   2      0=16,1=32,2=64 (drives REX.W and Iv width)
//  in_reg     in   8      reg_id_t for Gv / fixed-reg slot
//  in_rm_mem  in   1      Ev slot is memory (else register in_base)
//  in_base    in   8      reg_id_t base; RIP=rip-relative; 0=no base
//  in_index   in   8      reg_id_t index; 0=no index
//  in_scale   in   2      SIB scale
//  in_disp    in   DISP_W displacement
//  in_imm     in   IMM_W  immediate / branch offset
//  out_valid  out  1      out_byte valid
//  out_ready  in   1      consumer accepts byte
//  out_byte   out  8      current operand byte
//  out_last   out  1      out_byte is final byte of this request
//  rex_bits   out  4      {W,R,X,B}, registered at accept, held until next accept
//  done       out  1      1-cycle pulse: request finished (bytes sent or error)
//  err        out  1      qualifies done: illegal request, no bytes emitted
//  len        out  4      total bytes emitted (0..14), valid with done
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; out_valid=out_last=done=err=0; out_byte=0; rex_bits=0; len=0. Async assert
//   mid-request abandons it: no further bytes, no done.
//  FSM IDLE->{MODRM|DISP|IMM|FIN}; MODRM->SIB|DISP|IMM|FIN; SIB->DISP|IMM|FIN; DISP->IMM|FIN; IMM->FIN;
//   FIN->IDLE. Byte states advance only on out_valid&&out_ready; out_byte/out_last stable while stalled.
//  in_ready=1 only in IDLE. Accept at cycle N -> first byte valid at N+1; 1 byte/cycle without backpressure.
//  FIN: done=1 for exactly one cycle, the cycle after the last byte handshake (N+1 if zero bytes or err);
//   in_ready=0 in FIN, a new request is accepted no earlier than the cycle after done.
//  REX: W=(opsize==64); R=in_reg[3] if Gv present; B=rm/base[3] (or in_reg[3] for fixed-reg modes);
//   X=index[3].
//  ModRM reg field = in_reg[2:0]; for Ev-only modes reg=0 (group /digit supplied by opcode stage).
//  Ev register: mod=11, rm=base[2:0].
//  Ev memory: base==RIP -> mod=00 rm=101 disp32. Else SIB iff index!=0 || base==0 || base[2:0]==100:
//   rm=100, SIB={scale, index?index[2:0]:100, base?base[2:0]:101}.
//  mod: no base -> 00 + disp32; disp==0 && base[2:0]!=101 -> 00; -128<=disp<=127 -> 01 disp8; else 10 disp32.
//  Imm length: Ib/Jb=1, Iz/Jz=4, Iv=2/4/8 by in_opsize. Disp then imm, each little-endian.
//  Errors (done&&err, len=0): index==RSP (id 0x84); M/GV_M with in_rm_mem=0; reg ids not GPR
//   (id[7:4]!=4'b1000) where GPR required; in_opsize==3.
//  len saturates never: max ModRM+SIB+disp32+imm64 = 14.
// STRUCTURE
//  Utilities package: enc_mode_t, enc_req_t struct, reuse reg_id_t, RIP, RIMM, RAX..R15 constants.
//  Sub-module operand_enc_plan (combinational): request -> {modrm, sib, has_modrm, has_sib, disp_len,
//   imm_len, rex_bits, err}; top registers plan at accept and runs byte FSM with 4-bit byte counter.
// TESTING
//  GV_EV reg=RCX rm reg RBX -> bytes CB, last=1, len=1, rex_bits=0000, done at N+2.
//  GV_EV reg=RAX mem base=RSP disp=8 -> 44 24 08, len=3; base=RBP disp=0, reg=RDX -> 55 00.
//  GV_M reg=RAX base=RIP disp=0x12345678 -> 05 78 56 34 12; base=0 index=0 -> SIB 25 + disp32.
//  RAX$R8_IV opsize=64 imm=0x1122334455667788 -> 88 77 66 55 44 33 22 11, rex_bits=1000, len=8.
//  EV_GV index=RSP -> done&&err at N+1, no out_valid; out_ready toggled 1/0 on 14-byte request -> each byte
//   held stable while stalled, no loss/dup.
//  Random round-trip vs decode_operands: encode->decode yields identical operand fields and byte count;
//   reset asserted mid-DISP -> out_valid=0, in_ready=1 immediately.

Source files
------------

// File: rtl/operand_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : operand_encoder_pkg
// Brief    : Shared types, register ids and sequencing helpers for the
//            x86-64 operand byte encoder.
// Revision : 1.0 - initial release
// ============================================================================
package operand_encoder_pkg;

  // Register identifiers: GPRs live at 0x80..0x8F, 0x00 means "absent".
  typedef logic [7:0] reg_id_t;

  localparam reg_id_t NOREG = 8'h00;
  localparam reg_id_t RIP   = 8'h10;
  localparam reg_id_t RIMM  = 8'h20;
  localparam reg_id_t RAX   = 8'h80;
  localparam reg_id_t RCX   = 8'h81;
  localparam reg_id_t RDX   = 8'h82;
  localparam reg_id_t RBX   = 8'h83;
  localparam reg_id_t RSP   = 8'h84;
  localparam reg_id_t RBP   = 8'h85;
  localparam reg_id_t RSI   = 8'h86;
  localparam reg_id_t RDI   = 8'h87;
  localparam reg_id_t R8    = 8'h88;
  localparam reg_id_t R9    = 8'h89;
  localparam reg_id_t R10   = 8'h8A;
  localparam reg_id_t R11   = 8'h8B;
  localparam reg_id_t R12   = 8'h8C;
  localparam reg_id_t R13   = 8'h8D;
  localparam reg_id_t R14   = 8'h8E;
  localparam reg_id_t R15   = 8'h8F;

  // Operand shapes. Fixed-register forms carry the register in the opcode,
  // so they emit no ModRM; the *_IV forms add an opsize-wide immediate.
  typedef enum logic [4:0] {
    RAX_R8     = 5'd0,  RCX_R9     = 5'd1,  RDX_R10    = 5'd2,  RBX_R11    = 5'd3,
    RSP_R12    = 5'd4,  RBP_R13    = 5'd5,  RSI_R14    = 5'd6,  RDI_R15    = 5'd7,
    RAX_R8_IV  = 5'd8,  RCX_R9_IV  = 5'd9,  RDX_R10_IV = 5'd10, RBX_R11_IV = 5'd11,
    RSP_R12_IV = 5'd12, RBP_R13_IV = 5'd13, RSI_R14_IV = 5'd14, RDI_R15_IV = 5'd15,
    EV         = 5'd16, EV_GV      = 5'd17, EV_IB      = 5'd18, EV_IZ      = 5'd19,
    EV_IV      = 5'd20, GV_EV      = 5'd21, GV_M       = 5'd22, RAX_IZ     = 5'd23,
    JZ         = 5'd24, JB         = 5'd25, M          = 5'd26, NONE       = 5'd27
  } enc_mode_t;

  typedef struct packed {
    enc_mode_t  mode;
    logic [1:0] opsize;
    reg_id_t    reg_id;
    logic       rm_mem;
    reg_id_t    base;
    reg_id_t    index;
    logic [1:0] scale;
  } enc_req_t;

  typedef struct packed {
    logic [7:0] modrm;
    logic [7:0] sib;
    logic       has_modrm;
    logic       has_sib;
    logic [2:0] disp_len;
    logic [3:0] imm_len;
    logic [3:0] rex;
    logic       err;
  } enc_plan_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MODRM = 3'd1,
    ST_SIB   = 3'd2,
    ST_DISP  = 3'd3,
    ST_IMM   = 3'd4,
    ST_FIN   = 3'd5
  } enc_state_t;

  function automatic logic is_gpr(input reg_id_t id);
    return id[7:4] == 4'b1000;
  endfunction

  // First non-empty field after field s; later assignments take priority.
  function automatic enc_state_t next_field(input enc_state_t s, input enc_plan_t p);
    enc_state_t r;
    r = ST_FIN;
    if (p.imm_len != 4'd0 && s inside {ST_IDLE, ST_MODRM, ST_SIB, ST_DISP}) r = ST_IMM;
    if (p.disp_len != 3'd0 && s inside {ST_IDLE, ST_MODRM, ST_SIB}) r = ST_DISP;
    if (p.has_sib && s inside {ST_IDLE, ST_MODRM}) r = ST_SIB;
    if (p.has_modrm && s == ST_IDLE) r = ST_MODRM;
    return r;
  endfunction

  // More bytes remain inside the current multi-byte field.
  function automatic logic more_in_field(input enc_state_t s, input logic [3:0] cnt,
                                         input enc_plan_t p);
    logic [4:0] nxt;
    nxt = {1'b0, cnt} + 5'd1;
    return (s == ST_DISP && nxt < {2'b00, p.disp_len}) ||
           (s == ST_IMM  && nxt < {1'b0, p.imm_len});
  endfunction

  function automatic logic is_last(input enc_state_t s, input logic [3:0] cnt,
                                   input enc_plan_t p);
    return !more_in_field(s, cnt, p) && (next_field(s, p) == ST_FIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/operand_encoder_plan.sv
`default_nettype none
// ============================================================================
// Module   : operand_encoder_plan
// Brief    : Combinational planner: turns one operand request into ModRM/SIB
//            bytes, field lengths, REX.WRXB and an error flag.
// Revision : 1.0 - initial release
// ============================================================================
module operand_encoder_plan
  import operand_encoder_pkg::*;
#(
  parameter int DISP_W = 32
) (
  input  enc_req_t          i_req,
  input  logic [DISP_W-1:0] i_disp,
  output enc_plan_t         o_plan
);

  localparam logic signed [DISP_W-1:0] c_D8_MIN = DISP_W'(-128);
  localparam logic signed [DISP_W-1:0] c_D8_MAX = DISP_W'(127);

  logic w_d_zero;
  logic w_d_fit8;
  assign w_d_zero = (i_disp == '0);
  assign w_d_fit8 = ($signed(i_disp) >= c_D8_MIN) && ($signed(i_disp) <= c_D8_MAX);

  logic       w_fixed, w_fix_iv, w_has_gv, w_has_ev, w_need_mem, w_known, w_mem;
  logic       w_rip, w_sib, w_bad_mem;
  logic [1:0] w_mod;
  logic [2:0] w_rm;
  logic [3:0] w_iv_len;

  // Classify the mode, pick ModRM/SIB addressing form and validate operands.
  always_comb begin
    o_plan     = '0;
    w_fixed    = (i_req.mode <= RDI_R15_IV);
    w_fix_iv   = w_fixed && (i_req.mode >= RAX_R8_IV);
    w_has_gv   = i_req.mode inside {EV_GV, GV_EV, GV_M};
    w_has_ev   = w_has_gv || (i_req.mode inside {EV, EV_IB, EV_IZ, EV_IV, M});
    w_need_mem = i_req.mode inside {GV_M, M};
    w_known    = (i_req.mode <= NONE);
    w_mem      = w_has_ev && i_req.rm_mem;
    w_rip      = (i_req.base == RIP);

    case (i_req.opsize)
      2'd0:    w_iv_len = 4'd2;
      2'd1:    w_iv_len = 4'd4;
      2'd2:    w_iv_len = 4'd8;
      default: w_iv_len = 4'd0;
    endcase

    case (i_req.mode)
      EV_IB, JB:          o_plan.imm_len = 4'd1;
      EV_IZ, RAX_IZ, JZ:  o_plan.imm_len = 4'd4;
      EV_IV:              o_plan.imm_len = w_iv_len;
      default:            o_plan.imm_len = w_fix_iv ? w_iv_len : 4'd0;
    endcase

    // SIB is needed for an index, an absolute address, or an RSP/R12 base.
    w_sib = w_mem && !w_rip &&
            (i_req.index != NOREG || i_req.base == NOREG || i_req.base[2:0] == 3'b100);

    w_mod = 2'b11;
    w_rm  = i_req.base[2:0];
    if (w_mem) begin
      if (w_rip) begin
        w_mod = 2'b00;
        w_rm  = 3'b101;
        o_plan.disp_len = 3'd4;
      end else begin
        w_rm = w_sib ? 3'b100 : i_req.base[2:0];
        if (i_req.base == NOREG) begin
          w_mod = 2'b00;
          o_plan.disp_len = 3'd4;
        end else if (w_d_zero && i_req.base[2:0] != 3'b101) begin
          w_mod = 2'b00;
        end else if (w_d_fit8) begin
          w_mod = 2'b01;
          o_plan.disp_len = 3'd1;
        end else begin
          w_mod = 2'b10;
          o_plan.disp_len = 3'd4;
        end
      end
    end

    o_plan.has_modrm = w_has_ev;
    o_plan.has_sib   = w_sib;
    o_plan.modrm     = {w_mod, (w_has_gv ? i_req.reg_id[2:0] : 3'b000), w_rm};
    o_plan.sib       = {i_req.scale,
                        (i_req.index != NOREG) ? i_req.index[2:0] : 3'b100,
                        (i_req.base  != NOREG) ? i_req.base[2:0]  : 3'b101};

    o_plan.rex[3] = (i_req.opsize == 2'd2);
    o_plan.rex[2] = w_has_gv && i_req.reg_id[3];
    o_plan.rex[1] = w_mem && is_gpr(i_req.index) && i_req.index[3];
    o_plan.rex[0] = w_fixed ? i_req.reg_id[3] :
                    (w_has_ev && is_gpr(i_req.base) && i_req.base[3]);

    w_bad_mem = w_mem &&
                ((i_req.index == RSP) ||
                 (i_req.index != NOREG && !is_gpr(i_req.index)) ||
                 (i_req.base != NOREG && !w_rip && !is_gpr(i_req.base)) ||
                 (w_rip && i_req.index != NOREG));

    o_plan.err = !w_known || (i_req.opsize == 2'd3) ||
                 (w_need_mem && !i_req.rm_mem) ||
                 ((w_has_gv || w_fixed) && !is_gpr(i_req.reg_id)) ||
                 (w_has_ev && !i_req.rm_mem && !is_gpr(i_req.base)) ||
                 w_bad_mem;
  end

endmodule
`default_nettype wire

// File: rtl/operand_encoder.sv
`default_nettype none
// ============================================================================
// Module   : operand_encoder
// Brief    : Serializes x86-64 operand bytes (ModRM, SIB, disp, imm) one per
//            cycle with valid/ready handshake and reports REX.WRXB bits.
// Revision : 1.0 - initial release
// ============================================================================
module operand_encoder
  import operand_encoder_pkg::*;
#(
  parameter int DISP_W = 32,
  parameter int IMM_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mode,
  input  logic [1:0]        in_opsize,
  input  logic [7:0]        in_reg,
  input  logic              in_rm_mem,
  input  logic [7:0]        in_base,
  input  logic [7:0]        in_index,
  input  logic [1:0]        in_scale,
  input  logic [DISP_W-1:0] in_disp,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic [3:0]        rex_bits,
  output logic              done,
  output logic              err,
  output logic [3:0]        len
);

  enc_req_t          w_req;
  enc_plan_t         w_plan;
  enc_plan_t         r_plan;
  enc_state_t        r_state;
  enc_state_t        w_first;
  enc_state_t        w_nxt_st;
  logic [3:0]        r_cnt;
  logic [3:0]        w_nxt_cnt;
  logic [3:0]        r_len;
  logic [DISP_W-1:0] r_disp;
  logic [IMM_W-1:0]  r_imm;

  assign w_req = '{mode:   enc_mode_t'(in_mode), opsize: in_opsize, reg_id: in_reg,
                   rm_mem: in_rm_mem, base: in_base, index: in_index, scale: in_scale};

  operand_encoder_plan #(.DISP_W(DISP_W)) u_plan (
    .i_req  (w_req),
    .i_disp (in_disp),
    .o_plan (w_plan)
  );

  // Byte at position (s, cnt) of a planned request, fields little-endian.
  function automatic logic [7:0] byte_of(input enc_state_t s, input logic [3:0] cnt,
                                         input enc_plan_t p, input logic [DISP_W-1:0] d,
                                         input logic [IMM_W-1:0] im);
    logic [DISP_W-1:0] sd;
    logic [IMM_W-1:0]  si;
    sd = d  >> {cnt, 3'b000};
    si = im >> {cnt, 3'b000};
    case (s)
      ST_MODRM: return p.modrm;
      ST_SIB:   return p.sib;
      ST_DISP:  return sd[7:0];
      ST_IMM:   return si[7:0];
      default:  return 8'h00;
    endcase
  endfunction

  // Sequencing: first field at accept, and the position after the current byte.
  always_comb begin
    w_first   = next_field(ST_IDLE, w_plan);
    w_nxt_st  = r_state;
    w_nxt_cnt = r_cnt + 4'd1;
    if (!more_in_field(r_state, r_cnt, r_plan)) begin
      w_nxt_st  = next_field(r_state, r_plan);
      w_nxt_cnt = 4'd0;
    end
  end

  assign in_ready = (r_state == ST_IDLE);

  // Byte FSM: captures the plan at accept, steps on each output handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_plan    <= '0;
      r_disp    <= '0;
      r_imm     <= '0;
      r_cnt     <= 4'd0;
      r_len     <= 4'd0;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
      out_last  <= 1'b0;
      rex_bits  <= 4'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      len       <= 4'd0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_plan   <= w_plan;
            r_disp   <= in_disp;
            r_imm    <= in_imm;
            rex_bits <= w_plan.rex;
            r_cnt    <= 4'd0;
            r_len    <= 4'd0;
            if (w_plan.err || w_first == ST_FIN) begin
              r_state <= ST_FIN;
              done    <= 1'b1;
              err     <= w_plan.err;
              len     <= 4'd0;
            end else begin
              r_state   <= w_first;
              out_valid <= 1'b1;
              out_byte  <= byte_of(w_first, 4'd0, w_plan, in_disp, in_imm);
              out_last  <= is_last(w_first, 4'd0, w_plan);
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          err     <= 1'b0;
        end
        default: begin
          if (out_valid && out_ready) begin
            r_len <= r_len + 4'd1;
            if (w_nxt_st == ST_FIN) begin
              r_state   <= ST_FIN;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              err       <= 1'b0;
              len       <= r_len + 4'd1;
            end else begin
              r_state  <= w_nxt_st;
              r_cnt    <= w_nxt_cnt;
              out_byte <= byte_of(w_nxt_st, w_nxt_cnt, r_plan, r_disp, r_imm);
              out_last <= is_last(w_nxt_st, w_nxt_cnt, r_plan);
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
